// File: rtl/sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sched_pkg
//  Brief    : Shared state encoding, default timeout and clog2 helper for the
//             tick-driven channel sampling scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package sched_pkg;

    // Default watchdog window in Clk cycles spent waiting for Done
    localparam int c_TIMEOUT_DEFAULT = 1000;

    // Scheduler state encoding
    localparam int                c_ST_W     = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_ISSUE = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_WAIT  = 2'd2;
    localparam logic [c_ST_W-1:0] c_ST_NEXT  = 2'd3;

    typedef enum logic [c_ST_W-1:0] {
        S_IDLE  = c_ST_IDLE,
        S_ISSUE = c_ST_ISSUE,
        S_WAIT  = c_ST_WAIT,
        S_NEXT  = c_ST_NEXT
    } sched_state_t;

    // Number of bits needed to hold values 0..value-1
    function automatic int sched_clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sched_next_ch.sv
`default_nettype none
// ============================================================================
//  Module   : sched_next_ch
//  Brief    : Combinational finder for the next channel to serve. With i_first
//             set it returns the lowest set bit of i_mask; otherwise the lowest
//             set bit strictly above i_cur_idx. o_valid low means none left.
//  Revision : 1.0  initial release
// ============================================================================
module sched_next_ch #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [CH_W-1:0]   i_cur_idx,
    input  logic              i_first,
    output logic [CH_W-1:0]   o_idx,
    output logic              o_valid
);

    // Scan from the top down so the last hit left standing is the lowest eligible bit
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_mask[i] && (i_first || (CH_W'(i) > i_cur_idx))) begin
                o_idx   = CH_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tick_sample_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tick_sample_scheduler
//  Brief    : Runs one measurement round per timer Tick over the channels
//             enabled in ChMask, lowest index first, using a Start/Done
//             handshake to a shared front-end. Each channel is guarded by a
//             watchdog; overrun and timeout conditions are kept as sticky flags.
//  Revision : 1.0  initial release
// ============================================================================
module tick_sample_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CH_W        = sched_clog2(NUM_CH),
    parameter int TIMEOUT_CYC = c_TIMEOUT_DEFAULT,
    parameter int TO_W        = sched_clog2(TIMEOUT_CYC)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Tick,
    input  logic              Enable,
    input  logic [NUM_CH-1:0] ChMask,
    input  logic              ClrFlags,
    input  logic              Done,
    output logic              Start,
    output logic [CH_W-1:0]   ChSel,
    output logic              Busy,
    output logic              RoundDone,
    output logic              Overrun,
    output logic              TimeoutErr,
    output logic [CH_W-1:0]   ErrCh
);

    // Last watchdog count before a channel is abandoned
    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    sched_state_t       r_state;
    logic [NUM_CH-1:0]  r_mask;
    logic [TO_W-1:0]    r_to_cnt;

    logic               w_find_first;
    logic [NUM_CH-1:0]  w_find_mask;
    logic [CH_W-1:0]    w_next_idx;
    logic               w_found;

    // In IDLE the finder looks at the live mask for the first channel of a new
    // round; otherwise it walks the mask latched at round start above ChSel.
    assign w_find_first = (r_state == S_IDLE);
    assign w_find_mask  = w_find_first ? ChMask : r_mask;

    sched_next_ch #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_next_ch (
        .i_mask    (w_find_mask),
        .i_cur_idx (ChSel),
        .i_first   (w_find_first),
        .o_idx     (w_next_idx),
        .o_valid   (w_found)
    );

    // Round sequencer, watchdog counter and sticky flags, all outputs registered
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_mask     <= '0;
            r_to_cnt   <= '0;
            Start      <= 1'b0;
            ChSel      <= '0;
            Busy       <= 1'b0;
            RoundDone  <= 1'b0;
            Overrun    <= 1'b0;
            TimeoutErr <= 1'b0;
            ErrCh      <= '0;
        end else begin
            Start     <= 1'b0;
            RoundDone <= 1'b0;

            // Clear first so that a flag being set in this same cycle wins
            if (ClrFlags) begin
                Overrun    <= 1'b0;
                TimeoutErr <= 1'b0;
                ErrCh      <= '0;
            end

            // The RoundDone cycle is still treated as part of the round
            if (Tick && ((r_state != S_IDLE) || RoundDone)) begin
                Overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (Tick && Enable && !RoundDone && w_found) begin
                        r_mask  <= ChMask;
                        ChSel   <= w_next_idx;
                        Start   <= 1'b1;
                        Busy    <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    r_to_cnt <= '0;
                    r_state  <= S_WAIT;
                end

                S_WAIT: begin
                    if (Done) begin
                        r_state <= S_NEXT;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        TimeoutErr <= 1'b1;
                        ErrCh      <= ChSel;
                        r_state    <= S_NEXT;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end

                S_NEXT: begin
                    if (w_found) begin
                        ChSel   <= w_next_idx;
                        Start   <= 1'b1;
                        r_state <= S_ISSUE;
                    end else begin
                        RoundDone <= 1'b1;
                        Busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_sample_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tick_sample_scheduler
//  Brief    : Self-checking bench for tick_sample_scheduler (4 channels, 8-cycle
//             watchdog). A reference model plans each accepted round as a
//             timeline of Start / Done / timeout / RoundDone step numbers from
//             the per-channel response delays, and every cycle is compared.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tick_sample_scheduler;

    localparam int T    = 8;
    localparam int MAXS = 4096;
    localparam int NV   = 9;

    logic       Clk;
    logic       Reset;
    logic       Tick;
    logic       Enable;
    logic [3:0] ChMask;
    logic       ClrFlags;
    logic       Done;
    logic       Start;
    logic [1:0] ChSel;
    logic       Busy;
    logic       RoundDone;
    logic       Overrun;
    logic       TimeoutErr;
    logic [1:0] ErrCh;

    tick_sample_scheduler #(
        .NUM_CH      (4),
        .CH_W        (2),
        .TIMEOUT_CYC (T),
        .TO_W        (3)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Tick       (Tick),
        .Enable     (Enable),
        .ChMask     (ChMask),
        .ClrFlags   (ClrFlags),
        .Done       (Done),
        .Start      (Start),
        .ChSel      (ChSel),
        .Busy       (Busy),
        .RoundDone  (RoundDone),
        .Overrun    (Overrun),
        .TimeoutErr (TimeoutErr),
        .ErrCh      (ErrCh)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Scenario record: stimulus plus the outcome expected at the end of the round.
    // dly[c] is the number of WAIT cycles before Done for channel c (>T: never).
    typedef struct packed {
        logic [3:0]      mask;
        logic            en;
        logic [3:0][7:0] dly;
        logic [7:0]      tick2;
        logic [3:0]      exp_starts;
        logic            exp_ovr;
        logic            exp_to;
        logic [1:0]      exp_errch;
    } vec_t;

    vec_t tab [NV];

    // Model timeline, indexed by step (step n = outputs seen after clock edge n)
    bit  e_start [MAXS];
    bit  e_done  [MAXS];
    bit  e_rd    [MAXS];
    int  e_ch    [MAXS];
    int  e_to    [MAXS];

    // Model's expected outputs for the most recent step
    logic       m_start, m_busy, m_rd, m_ovr, m_to;
    logic [1:0] m_chsel, m_errch;

    int  n;
    int  checks;
    int  failures;
    int  st_cnt;
    bit  use_tab;
    int  tab_dly [4];

    function automatic vec_t mk(input logic [3:0] mask, input logic en,
                                input int d3, input int d2, input int d1, input int d0,
                                input int tick2, input int starts,
                                input logic ovr, input logic to, input logic [1:0] errch);
        vec_t v;
        v.mask       = mask;
        v.en         = en;
        v.dly        = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
        v.tick2      = 8'(tick2);
        v.exp_starts = 4'(starts);
        v.exp_ovr    = ovr;
        v.exp_to     = to;
        v.exp_errch  = errch;
        return v;
    endfunction

    // One clock cycle: update the model from the inputs, drive them, compare outputs
    task automatic step(input bit rst_i, input bit tick_i, input bit en_i,
                        input logic [3:0] mask_i, input bit clr_i, input bit spur_i);
        bit accept;
        bit ovr_set;
        bit done_i;
        int s;
        int d;
        @(negedge Clk);
        n = n + 1;
        if (n + 64 >= MAXS) begin
            $display("FAIL step_budget step=%0d limit=%0d", n, MAXS);
            failures = failures + 1;
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "step budget exhausted");
        end
        // Stray Done only where the front-end is not being waited on (IDLE or ISSUE)
        done_i = e_done[n] || (spur_i && (!m_busy || m_start));
        if (rst_i) begin
            for (int k = n; k < MAXS; k++) begin
                e_start[k] = 1'b0;
                e_done[k]  = 1'b0;
                e_rd[k]    = 1'b0;
                e_ch[k]    = 0;
                e_to[k]    = -1;
            end
            m_start = 1'b0; m_chsel = 2'd0; m_busy = 1'b0; m_rd = 1'b0;
            m_ovr   = 1'b0; m_to    = 1'b0; m_errch = 2'd0;
        end else begin
            accept  = tick_i && en_i && (mask_i != 4'b0000) && !m_busy && !m_rd;
            ovr_set = tick_i && (m_busy || m_rd);
            if (accept) begin
                s = n;
                for (int ch = 0; ch < 4; ch++) begin
                    if (mask_i[ch]) begin
                        d = use_tab ? tab_dly[ch] : int'($urandom_range(1, T + 2));
                        e_start[s] = 1'b1;
                        e_ch[s]    = ch;
                        if (d >= 1 && d <= T) begin
                            e_done[s + 1 + d] = 1'b1;
                            s = s + 2 + d;
                        end else begin
                            e_to[s + 1 + T] = ch;
                            s = s + 2 + T;
                        end
                    end
                end
                e_rd[s] = 1'b1;
            end
            m_start = e_start[n];
            if (e_start[n]) begin
                m_chsel = 2'(e_ch[n]);
                m_busy  = 1'b1;
            end
            if (e_rd[n]) m_busy = 1'b0;
            m_rd = e_rd[n];
            if (clr_i) begin
                m_ovr = 1'b0; m_to = 1'b0; m_errch = 2'd0;
            end
            if (ovr_set) m_ovr = 1'b1;
            if (e_to[n] >= 0) begin
                m_to    = 1'b1;
                m_errch = 2'(e_to[n]);
            end
        end
        Reset    = rst_i;
        Tick     = tick_i;
        Enable   = en_i;
        ChMask   = mask_i;
        ClrFlags = clr_i;
        Done     = done_i;
        @(posedge Clk);
        #1;
        if (Start === 1'b1) st_cnt = st_cnt + 1;
        checks = checks + 1;
        if (Start !== m_start || ChSel !== m_chsel || Busy !== m_busy || RoundDone !== m_rd ||
            Overrun !== m_ovr || TimeoutErr !== m_to || ErrCh !== m_errch) begin
            failures = failures + 1;
            $display("FAIL outputs step=%0d got St=%b Sel=%0d Bsy=%b RD=%b Ov=%b TO=%b EC=%0d want St=%b Sel=%0d Bsy=%b RD=%b Ov=%b TO=%b EC=%0d",
                     n, Start, ChSel, Busy, RoundDone, Overrun, TimeoutErr, ErrCh,
                     m_start, m_chsel, m_busy, m_rd, m_ovr, m_to, m_errch);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached at step=%0d", n);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int   guard;
        vec_t v;

        n = -1; checks = 0; failures = 0; st_cnt = 0; use_tab = 1'b0;
        for (int k = 0; k < MAXS; k++) begin
            e_start[k] = 1'b0; e_done[k] = 1'b0; e_rd[k] = 1'b0; e_ch[k] = 0; e_to[k] = -1;
        end
        for (int c = 0; c < 4; c++) tab_dly[c] = 1;
        m_start = 1'b0; m_chsel = 2'd0; m_busy = 1'b0; m_rd = 1'b0;
        m_ovr = 1'b0; m_to = 1'b0; m_errch = 2'd0;
        Reset = 1'b1; Tick = 1'b0; Enable = 1'b0; ChMask = 4'b0; ClrFlags = 1'b0; Done = 1'b0;

        //               mask     en d3  d2  d1  d0 tick2 starts ovr to errch
        tab[0] = mk(4'b1011, 1'b1, 5,  0,  5,  5,  0,    3,   0,  0, 2'd0);
        tab[1] = mk(4'b0000, 1'b1, 1,  1,  1,  1,  0,    0,   0,  0, 2'd0);
        tab[2] = mk(4'b1111, 1'b0, 1,  1,  1,  1,  0,    0,   0,  0, 2'd0);
        tab[3] = mk(4'b0110, 1'b1, 0,  5,  5,  0,  3,    2,   1,  0, 2'd0);
        tab[4] = mk(4'b1111, 1'b1, 4, 99,  2,  2,  0,    4,   0,  1, 2'd2);
        tab[5] = mk(4'b0001, 1'b1, 0,  0,  0,  8,  0,    1,   0,  0, 2'd0);
        tab[6] = mk(4'b1000, 1'b1, 9,  0,  0,  0,  0,    1,   0,  1, 2'd3);
        tab[7] = mk(4'b0101, 1'b1, 0,  1,  0,  1,  0,    2,   0,  0, 2'd0);
        tab[8] = mk(4'b1010, 1'b1, 8,  0,  7,  0,  1,    2,   1,  0, 2'd0);

        // Reset state
        step(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1);
        checks = checks + 1;
        if (Start !== 1'b0 || Busy !== 1'b0 || RoundDone !== 1'b0 || ChSel !== 2'd0 ||
            Overrun !== 1'b0 || TimeoutErr !== 1'b0 || ErrCh !== 2'd0) begin
            failures = failures + 1;
            $display("FAIL reset_state got St=%b Bsy=%b RD=%b Sel=%0d Ov=%b TO=%b EC=%0d want all 0",
                     Start, Busy, RoundDone, ChSel, Overrun, TimeoutErr, ErrCh);
        end

        // Table-driven rounds; Enable dropped and ChMask inverted once a round runs
        use_tab = 1'b1;
        for (int i = 0; i < NV; i++) begin
            v = tab[i];
            for (int c = 0; c < 4; c++) tab_dly[c] = int'(v.dly[c]);
            st_cnt = 0;
            step(1'b0, 1'b1, v.en, v.mask, 1'b0, 1'b0);
            guard = 0;
            while ((m_busy || m_rd) && guard < 200) begin
                guard = guard + 1;
                step(1'b0, (v.tick2 != 8'd0) && (guard == int'(v.tick2)), 1'b0, ~v.mask, 1'b0, 1'b0);
            end
            checks = checks + 1;
            if (guard >= 200) begin
                failures = failures + 1;
                $display("FAIL vec%0d_round_end still busy after %0d cycles, want idle", i, guard);
            end
            checks = checks + 1;
            if (st_cnt != int'(v.exp_starts)) begin
                failures = failures + 1;
                $display("FAIL vec%0d_starts got %0d want %0d", i, st_cnt, v.exp_starts);
            end
            checks = checks + 1;
            if (Overrun !== v.exp_ovr || TimeoutErr !== v.exp_to || ErrCh !== v.exp_errch) begin
                failures = failures + 1;
                $display("FAIL vec%0d_flags got Ov=%b TO=%b EC=%0d want Ov=%b TO=%b EC=%0d",
                         i, Overrun, TimeoutErr, ErrCh, v.exp_ovr, v.exp_to, v.exp_errch);
            end
            step(1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 1'b0);
            checks = checks + 1;
            if (Overrun !== 1'b0 || TimeoutErr !== 1'b0 || ErrCh !== 2'd0) begin
                failures = failures + 1;
                $display("FAIL vec%0d_clrflags got Ov=%b TO=%b EC=%0d want 0 0 0",
                         i, Overrun, TimeoutErr, ErrCh);
            end
        end

        // Tick in the RoundDone cycle: dropped and flagged as overrun
        tab_dly[0] = 1;
        step(1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
        guard = 0;
        while (!m_rd && guard < 50) begin
            guard = guard + 1;
            step(1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
        checks = checks + 1;
        if (Overrun !== 1'b1 || Busy !== 1'b0 || Start !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL tick_at_rounddone got Ov=%b Bsy=%b St=%b want Ov=1 Bsy=0 St=0",
                     Overrun, Busy, Start);
        end
        step(1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 1'b0);

        // Done pulses while idle are ignored
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b1);
        checks = checks + 1;
        if (Busy !== 1'b0 || Start !== 1'b0 || RoundDone !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL done_in_idle got Bsy=%b St=%b RD=%b want 0 0 0", Busy, Start, RoundDone);
        end

        // Reset while waiting on channel 1, then a fresh round from channel 0
        tab_dly[0] = 2; tab_dly[1] = 99;
        step(1'b0, 1'b1, 1'b1, 4'b0011, 1'b0, 1'b0);
        guard = 0;
        while (!(m_start && m_chsel == 2'd1) && guard < 50) begin
            guard = guard + 1;
            step(1'b0, 1'b0, 1'b1, 4'b0011, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b1, 4'b0011, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 4'b0011, 1'b0, 1'b0);
        checks = checks + 1;
        if (Start !== 1'b0 || Busy !== 1'b0 || RoundDone !== 1'b0 || ChSel !== 2'd0 ||
            Overrun !== 1'b0 || TimeoutErr !== 1'b0 || ErrCh !== 2'd0) begin
            failures = failures + 1;
            $display("FAIL reset_midround got St=%b Bsy=%b RD=%b Sel=%0d Ov=%b TO=%b EC=%0d want all 0",
                     Start, Busy, RoundDone, ChSel, Overrun, TimeoutErr, ErrCh);
        end
        tab_dly[0] = 1; tab_dly[1] = 1;
        step(1'b0, 1'b1, 1'b1, 4'b0011, 1'b0, 1'b0);
        checks = checks + 1;
        if (Start !== 1'b1 || Busy !== 1'b1 || ChSel !== 2'd0) begin
            failures = failures + 1;
            $display("FAIL restart_after_reset got St=%b Bsy=%b Sel=%0d want St=1 Bsy=1 Sel=0",
                     Start, Busy, ChSel);
        end
        guard = 0;
        while ((m_busy || m_rd) && guard < 100) begin
            guard = guard + 1;
            step(1'b0, 1'b0, 1'b1, 4'b0011, 1'b0, 1'b0);
        end

        // Randomized traffic with random front-end response times
        use_tab = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            step(1'b0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 4) != 0,
                 4'($urandom),
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
